// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline sequencer.
// Optional feature macro used by this slice: ARM_PIPE_FORWARDING_EN.
package arm_pipe_pkg;

    // Default widths for the sequencer and hazard unit
    localparam int REG_W_DEF = 4;
    localparam int CNT_W_DEF = 16;

    // Instruction loaded into IF/ID when it is flushed
    localparam logic [31:0] NOP_INSTR = 32'hE0000000;

    // Data-cache miss tracking states
    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/arm_hazard_detect.sv
// Read-after-write hazard detection for the instruction in ID.
// ARM_PIPE_FORWARDING_EN: only load-use hazards stall; otherwise any pending write does.
module arm_hazard_detect
    import arm_pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hazard
);

    logic match1;
    logic match2;

`ifdef ARM_PIPE_FORWARDING_EN
    // MEM results and non-load EXE results reach ID via the forwarding paths
    logic unused_mem_fields;
    assign unused_mem_fields = ^{mem_dest, mem_wb_en};

    // Stall only when a load in EXE produces a source of the ID instruction
    always_comb begin
        match1 = exe_wb_en & exe_mem_read & (id_src1 == exe_dest);
        match2 = exe_wb_en & exe_mem_read & (id_src2 == exe_dest);
    end
`else
    // Without forwarding every pending write matters, loads or not
    logic unused_exe_load;
    assign unused_exe_load = exe_mem_read;

    // Stall on any writer in EXE or MEM targeting an ID source
    always_comb begin
        match1 = (exe_wb_en & (id_src1 == exe_dest))
               | (mem_wb_en & (id_src1 == mem_dest));
        match2 = (exe_wb_en & (id_src2 == exe_dest))
               | (mem_wb_en & (id_src2 == mem_dest));
    end
`endif

    // Only sources the instruction really reads can create a hazard
    always_comb begin
        hazard = (id_use_src1 & match1) | (id_use_src2 & match2);
    end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// Pipeline sequencer: freeze/flush/bubble controls, cache-miss FSM, event counters.
// Hazard policy follows ARM_PIPE_FORWARDING_EN inside arm_hazard_detect.
module arm_pipe_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             cache_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idexe_flush,
    output logic             mem_freeze,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] miss_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic hazard;
    logic miss_start;
    logic stall_evt;
    logic flush_evt;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    arm_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src1  (id_use_src1),
        .id_use_src2  (id_use_src2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    // Miss FSM next state and the Mealy memory freeze
    always_comb begin
        state_d    = state_q;
        miss_start = 1'b0;
        mem_freeze = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_req && !cache_ready) begin
                    state_d    = MISS;
                    miss_start = 1'b1;
                    mem_freeze = 1'b1;
                end
            end
            MISS: begin
                if (cache_ready) begin
                    state_d = RUN;
                end else begin
                    mem_freeze = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Reset releases the freeze at once, even with a request still pending
        if (rst) begin
            mem_freeze = 1'b0;
        end
    end

    // Stage controls: a taken branch discards ID, so it overrides the stall
    always_comb begin
        pc_freeze   = hazard & ~branch_taken;
        ifid_freeze = hazard & ~branch_taken;
        ifid_flush  = branch_taken;
        idexe_flush = hazard | branch_taken;
    end

    // Counter events; a frozen pipeline makes no progress to count
    always_comb begin
        stall_evt   = hazard & ~branch_taken & ~mem_freeze;
        flush_evt   = branch_taken & ~mem_freeze;
        miss_cnt_d  = sat_inc(miss_cnt_q, miss_start);
        stall_cnt_d = sat_inc(stall_cnt_q, stall_evt);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_evt);
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign miss_cnt  = miss_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// Directed self-checking bench for arm_pipe_ctrl.
// Expectations adapt to ARM_PIPE_FORWARDING_EN when it is defined.
module tb_arm_pipe_ctrl;

    localparam int CW = 16;
    localparam int RW = 4;

`ifdef ARM_PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_src1;
    logic [RW-1:0] id_src2;
    logic          id_use_src1;
    logic          id_use_src2;
    logic [RW-1:0] exe_dest;
    logic          exe_wb_en;
    logic          exe_mem_read;
    logic [RW-1:0] mem_dest;
    logic          mem_wb_en;
    logic          branch_taken;
    logic          mem_req;
    logic          cache_ready;
    logic          pc_freeze;
    logic          ifid_freeze;
    logic          ifid_flush;
    logic          idexe_flush;
    logic          mem_freeze;
    logic [CW-1:0] miss_cnt;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    logic [4:0] ctrl;
    int n_assert = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int exp_miss = 0;

    // {pc_freeze, ifid_freeze, ifid_flush, idexe_flush, mem_freeze}
    assign ctrl = {pc_freeze, ifid_freeze, ifid_flush, idexe_flush, mem_freeze};

    always #5 clk = ~clk;

    arm_pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src1  (id_use_src1),
        .id_use_src2  (id_use_src2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .cache_ready  (cache_ready),
        .pc_freeze    (pc_freeze),
        .ifid_freeze  (ifid_freeze),
        .ifid_flush   (ifid_flush),
        .idexe_flush  (idexe_flush),
        .mem_freeze   (mem_freeze),
        .miss_cnt     (miss_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_src1      = '0;
        id_src2      = '0;
        id_use_src1  = 1'b0;
        id_use_src2  = 1'b0;
        exe_dest     = '0;
        exe_wb_en    = 1'b0;
        exe_mem_read = 1'b0;
        mem_dest     = '0;
        mem_wb_en    = 1'b0;
        branch_taken = 1'b0;
        mem_req      = 1'b0;
        cache_ready  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cnts(input string tag);
        chk({tag, "_miss"}, 32'(miss_cnt), 32'(exp_miss));
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick();
        tick();
        chk("reset_ctrl", 32'(ctrl), 32'h0);
        cnts("reset");
        rst = 1'b0;
        tick();

        // Miss lasting four cycles with a hazard present meanwhile
        mem_req      = 1'b1;
        exe_wb_en    = 1'b1;
        exe_mem_read = 1'b1;
        exe_dest     = 4'd3;
        id_src1      = 4'd3;
        id_use_src1  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("miss_freeze", 32'(ctrl), 32'b11011);
            tick();
            if (i == 0) exp_miss = 1;
            cnts("miss_hold");
        end
        clr();
        mem_req     = 1'b1;
        cache_ready = 1'b1;
        #1;
        chk("miss_release", 32'(ctrl), 32'h0);
        tick();
        cnts("miss_done");

        // Hit on the first request cycle: no freeze, no miss
        #1;
        chk("hit_ctrl", 32'(ctrl), 32'h0);
        tick();
        cnts("hit");
        clr();

        // Non-load writer in EXE
        exe_wb_en   = 1'b1;
        exe_dest    = 4'd3;
        id_src1     = 4'd3;
        id_use_src1 = 1'b1;
        #1;
        chk("alu_raw", 32'(ctrl), FWD ? 32'h0 : 32'b11010);
        tick();
        if (!FWD) exp_stall++;
        cnts("alu_raw");

        // Load-use in EXE stalls in both builds
        exe_mem_read = 1'b1;
        #1;
        chk("load_use", 32'(ctrl), 32'b11010);
        tick();
        exp_stall++;
        cnts("load_use");

        // The load has moved to MEM
        exe_wb_en    = 1'b0;
        exe_mem_read = 1'b0;
        exe_dest     = 4'd0;
        mem_wb_en    = 1'b1;
        mem_dest     = 4'd3;
        #1;
        chk("load_in_mem", 32'(ctrl), FWD ? 32'h0 : 32'b11010);
        tick();
        if (!FWD) exp_stall++;
        cnts("load_in_mem");
        clr();

        // Matching register that the instruction does not read
        exe_wb_en    = 1'b1;
        exe_mem_read = 1'b1;
        exe_dest     = 4'd3;
        id_src1      = 4'd3;
        #1;
        chk("unused_src", 32'(ctrl), 32'h0);
        tick();
        cnts("unused_src");
        clr();

        // Load-use on src2 with register 15
        exe_wb_en    = 1'b1;
        exe_mem_read = 1'b1;
        exe_dest     = 4'd15;
        id_src1      = 4'd15;
        id_src2      = 4'd15;
        id_use_src2  = 1'b1;
        #1;
        chk("src2_r15", 32'(ctrl), 32'b11010);
        tick();
        exp_stall++;
        cnts("src2_r15");

        // Different register: no hazard
        exe_dest = 4'd14;
        #1;
        chk("no_match", 32'(ctrl), 32'h0);
        tick();
        cnts("no_match");

        // Branch taken together with a hazard
        exe_dest     = 4'd15;
        branch_taken = 1'b1;
        #1;
        chk("branch_hazard", 32'(ctrl), 32'b00110);
        tick();
        exp_flush++;
        cnts("branch_hazard");
        clr();

        // Branch held during a two-cycle miss, then released
        mem_req      = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("branch_miss", 32'(ctrl), 32'b00111);
            tick();
            if (i == 0) exp_miss++;
            cnts("branch_miss");
        end
        cache_ready = 1'b1;
        #1;
        chk("branch_release", 32'(ctrl), 32'b00110);
        tick();
        exp_flush++;
        cnts("branch_release");
        clr();

        // Reset asserted in the middle of a miss
        mem_req = 1'b1;
        repeat (3) tick();
        exp_miss++;
        cnts("pre_reset");
        rst = 1'b1;
        #1;
        chk("rst_freeze", 32'(mem_freeze), 32'h0);
        exp_miss  = 0;
        exp_stall = 0;
        exp_flush = 0;
        cnts("rst_mid_miss");
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_freeze", 32'(mem_freeze), 32'h1);
        tick();
        exp_miss = 1;
        cnts("post_rst_run");
        cache_ready = 1'b1;
        tick();
        clr();

        // Saturation of the stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exe_wb_en    = 1'b1;
        exe_mem_read = 1'b1;
        exe_dest     = 4'd7;
        id_src1      = 4'd7;
        id_use_src1  = 1'b1;
        repeat (65534) tick();
        chk("sat_below", 32'(stall_cnt), 32'hFFFE);
        repeat (7) tick();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        clr();
        tick();
        chk("sat_idle", 32'(stall_cnt), 32'hFFFF);
        chk("sat_flush", 32'(flush_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_pipe_ctrl.md
# arm_pipe_ctrl

Central pipeline sequencer for the 5-stage ARM core with data cache. It produces the freeze, flush and bubble controls for the PC register, the IF/ID and ID/EXE pipeline registers, and the global memory freeze. It detects read-after-write hazards in ID and tracks data-cache misses with a small FSM. It also keeps saturating performance counters for miss, stall and flush events. It sits beside the datapath: inputs come from the ID, EXE and MEM stages and the cache, and outputs go to every pipeline register's freeze/flush pins.

## Interface
- CNT_W, 16, width of each performance counter
- REG_W, 4, register-index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_src1, id_src2  in  REG_W  source registers of the instruction in ID
- id_use_src1, id_use_src2  in  1  the ID instruction actually reads src1/src2
- exe_dest  in  REG_W  destination register in EXE
- exe_wb_en  in  1  the EXE instruction writes back
- exe_mem_read  in  1  the EXE instruction is a load
- mem_dest  in  REG_W  destination register in MEM
- mem_wb_en  in  1  the MEM instruction writes back
- branch_taken  in  1  a taken branch is resolved in EXE
- mem_req  in  1  the MEM stage holds a valid load/store
- cache_ready  in  1  the cache completes the current access this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold IF/ID
- ifid_flush  out  1  load NOP (32'hE0000000) into IF/ID
- idexe_flush  out  1  insert bubble into ID/EXE
- mem_freeze  out  1  freeze all pipeline registers; highest priority at every consumer
- miss_cnt, stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states: RUN, MISS.
  - RUN → MISS when mem_req & ~cache_ready.
  - MISS → RUN when cache_ready.
  - MISS holds otherwise.
- mem_freeze = (RUN & mem_req & ~cache_ready) | (MISS & ~cache_ready). It is Mealy, so it is asserted in the same cycle a miss is detected.
- hazard = id_use_src1 & match(id_src1) | id_use_src2 & match(id_src2), where match(r) is defined under Configuration.
- pc_freeze = ifid_freeze = hazard & ~branch_taken.
- idexe_flush = hazard | branch_taken.
- ifid_flush = branch_taken.
- Branch has priority over hazard: the ID instruction is discarded, so no stall is needed.
- All combinational outputs are still driven during mem_freeze. Consumers apply the priority rule mem_freeze > flush > freeze. Counters do not count during mem_freeze except miss_cnt.
- miss_cnt increments once per RUN→MISS transition.
- stall_cnt increments on every cycle where hazard & ~branch_taken & ~mem_freeze.
- flush_cnt increments on every cycle where branch_taken & ~mem_freeze.
- All counters saturate at all-ones and never wrap.

## Timing
- Reset: state=RUN and all counters 0. All outputs are 0 while rst is high, provided inputs are idle.
- Control outputs have zero latency (combinational). Counters update on the clk edge after the event.
- A miss that completes in one cycle (cache_ready high on the first request cycle) gives no freeze, no MISS entry and no miss_cnt increment.
- A load-use hazard gives exactly one stall cycle. On the next cycle the load is in MEM and the hazard clears (with FORWARDING_EN).
- If the cache resolves on the same cycle a branch is taken, mem_freeze=0 and both flushes are asserted.
- If rst is asserted while in MISS, the FSM returns to RUN immediately and mem_freeze drops asynchronously.
- Register index 15 (PC) is treated like any other index and is not special-cased.

## Configuration
- ARM_PIPE_FORWARDING_EN defined: match(r) = exe_wb_en & exe_mem_read & (r==exe_dest). Only load-use hazards stall; the forwarding unit covers all others.
- Not defined: match(r) = (exe_wb_en & r==exe_dest) | (mem_wb_en & r==mem_dest). This stalls on any pending write in EXE or MEM.

## Structure
- Package arm_pipe_pkg:
  - state enum {RUN, MISS}
  - REG_W and CNT_W defaults
  - NOP_INSTR = 32'hE0000000
- Sub-module arm_hazard_detect: purely combinational. Computes hazard from the ID/EXE/MEM fields and contains the ARM_PIPE_FORWARDING_EN selection.
- The top level holds the FSM, the output logic and the counters.

## Test plan
- Reset mid-MISS: with mem_req=1 and cache_ready=0 for 3 cycles, assert rst → mem_freeze=0 immediately, state=RUN, counters=0.
- Miss sequence: mem_req=1, cache_ready=0 for 4 cycles, then 1 → mem_freeze high for 4 cycles, miss_cnt=1, stall_cnt and flush_cnt unchanged.
- Load-use with FORWARDING_EN: exe_mem_read=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_use_src1=1 → one cycle of pc_freeze=ifid_freeze=idexe_flush=1, stall_cnt=1. Without FORWARDING_EN, the same hazard with exe_mem_read=0 also stalls.
- Branch over hazard: branch_taken=1 together with a RAW hazard → ifid_flush=idexe_flush=1, pc_freeze=0, flush_cnt=1, stall_cnt=0.
- Branch during miss: branch_taken=1 while in MISS for 2 cycles → flush outputs high, flush_cnt unchanged until cache_ready, then +1 on the release cycle.
- Saturation: force 2^CNT_W+5 stall cycles → stall_cnt holds at 16'hFFFF.
